csr_machine_unit: RTL

Machine-mode CSR file and trap sequencer that sits directly downstream of the interrupt controller. It consumes the controller's interrupt pulse and cause word, saves the interrupted PC, and redirects the core to the trap vector. It supplies the per-source enable mask back to the controller and, on `mret`, pulses the controller's interrupt-reset input. It also executes CSRRW/CSRRS/CSRRC accesses from the decode stage.

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_mcycle.sv | 41 ++++
 rtl/csr_machine_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, the CSR
// access opcode, the trap sequencer states and the mtvec/mepc low-bit mask.
package csr_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;

  localparam logic [AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [AW-1:0] CSR_MCYCLEH  = 12'hB80;

  // Low two bits of mtvec (mode, direct only) and mepc read as zero.
  localparam logic [XLEN-1:0] MTVEC_MODE_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } csr_state_e;

  // New CSR value for a read-modify-write access.
  function automatic logic [XLEN-1:0] csr_wval(csr_op_e op, logic [XLEN-1:0] old_v,
                                               logic [XLEN-1:0] wd);
    case (op)
      CSR_RW:  csr_wval = wd;
      CSR_RS:  csr_wval = old_v | wd;
      CSR_RC:  csr_wval = old_v & ~wd;
      default: csr_wval = old_v;
    endcase
  endfunction

endpackage

// File: rtl/csr_mcycle.sv
// 64-bit free-running cycle counter with separate low/high word load ports.
// Ports: clk_i, rst_i (async, active-high), wr_lo_i/wr_hi_i load strobes,
// wdata_i load value, count_o current count.
module csr_mcycle (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic [32:0] lo_inc;

  // A low-word load suppresses the carry; a high-word load drops it.
  always_comb begin
    lo_inc = {1'b0, lo_q} + 33'd1;
    lo_d   = lo_inc[31:0];
    hi_d   = hi_q + 32'(lo_inc[32]);
    if (wr_lo_i) begin
      lo_d = wdata_i;
      hi_d = hi_q;
    end else if (wr_hi_i) begin
      hi_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_machine_unit.sv
// Machine-mode CSR file and trap sequencer behind the interrupt controller.
// Optional feature macro: CSR_MCYCLE_EN adds the 64-bit mcycle counter.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   csr_op_i/addr_i/wdata_i  CSR access from decode (funct3, address, operand)
//   pc_i                 PC of the instruction in flight, saved on trap
//   int_i/mcause_i       interrupt pulse and cause from the controller
//   mret_i               mret decoded this cycle
//   rdata_o              pre-write value of the addressed CSR (combinational)
//   mie_o/mtvec_o/mepc_o registered CSR values
//   trap_o/int_rst_o/illegal_o  per-cycle strobes (combinational)
module csr_machine_unit
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  input  logic        int_i,
  input  logic [31:0] mcause_i,
  input  logic        mret_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        trap_o,
  output logic        int_rst_o,
  output logic        illegal_o
);

  csr_state_e      state_q, state_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  csr_op_e         op;
  logic            access;
  logic            hit;
  logic            wr_ok;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_cnt;
  logic        mcycle_wr_lo;
  logic        mcycle_wr_hi;

  assign mcycle_wr_lo = wr_ok && (addr_i == CSR_MCYCLE);
  assign mcycle_wr_hi = wr_ok && (addr_i == CSR_MCYCLEH);

  csr_mcycle u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_lo_i (mcycle_wr_lo),
    .wr_hi_i (mcycle_wr_hi),
    .wdata_i (wdata_i),
    .count_o (mcycle_cnt)
  );
`endif

  // Address decode and old-value mux; bit 2 of funct3 only selects zimm.
  always_comb begin
    op      = csr_op_e'(csr_op_i[1:0]);
    access  = (op != CSR_NONE);
    hit     = 1'b1;
    old_val = '0;
    case (addr_i)
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:   old_val = mcycle_cnt[31:0];
      CSR_MCYCLEH:  old_val = mcycle_cnt[63:32];
`endif
      default:      hit = 1'b0;
    endcase
    new_val = csr_wval(op, old_val, wdata_i);
    // RS/RC with a zero operand are pure reads.
    wr_ok   = access && hit && ((op == CSR_RW) || (wdata_i != '0));
  end

  // Trap sequencer and CSR next-state; trap capture overrides CSR writes.
  always_comb begin
    state_d    = state_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    trap_o     = 1'b0;
    int_rst_o  = 1'b0;
    illegal_o  = access && !hit;
    rdata_o    = (access && hit) ? old_val : '0;

    if (wr_ok) begin
      case (addr_i)
        CSR_MIE:      mie_d      = new_val;
        CSR_MTVEC:    mtvec_d    = new_val & ~MTVEC_MODE_MASK;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~MTVEC_MODE_MASK;
        CSR_MCAUSE:   mcause_d   = new_val;
        default:      ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (mret_i) begin
          illegal_o = 1'b1;
        end
        if (int_i) begin
          trap_o   = 1'b1;
          mepc_d   = pc_i & ~MTVEC_MODE_MASK;
          mcause_d = mcause_i;
          state_d  = ST_TRAP;
        end
      end
      ST_TRAP: begin
        // int_i is ignored here; the controller keeps the source pending.
        if (mret_i) begin
          int_rst_o = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      state_q    <= state_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mie_o   = mie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule
